// File: rtl/wb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_slave
// Brief    : Wishbone B4 classic slave. Decodes an address window onto an
//            internal word-organised RAM, inserts programmable wait states,
//            honours byte-lane selects on writes and returns registered
//            ack/err pulses plus registered read data.
// Revision : 1.0 - initial release
// ============================================================================
module wb_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);

    localparam int          c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_SPAN  = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  c_WAIT  = 4'(WAIT_STATES);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;
    localparam logic [1:0] c_S_TURN = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [3:0]         r_cnt;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdat;
    logic [3:0]         r_sel;
    logic               r_we;
    logic               r_ack;
    logic               r_err;
    logic [31:0]        r_rdat;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_req;
    logic               w_capture;
    logic               w_commit;
    logic               w_in_idle;
    logic [31:0]        w_ev_addr;
    logic [31:0]        w_ev_wdat;
    logic [3:0]         w_ev_sel;
    logic               w_ev_we;
    logic [32:0]        w_off;
    logic               w_err;
    logic               w_mem_wr;
    logic [c_IDX_W-1:0] w_idx;

    assign w_req     = wbs_cyc_i & wbs_stb_i;
    assign w_in_idle = (r_state == c_S_IDLE);
    assign w_capture = w_in_idle & w_req;

    // With zero wait states the commit happens on the capture edge itself,
    // so the request is evaluated straight from the bus in that case.
    assign w_ev_addr = w_in_idle ? wbs_addr_i : r_addr;
    assign w_ev_wdat = w_in_idle ? wbs_dat_i  : r_wdat;
    assign w_ev_sel  = w_in_idle ? wbs_sel_i  : r_sel;
    assign w_ev_we   = w_in_idle ? wbs_we_i   : r_we;

    // 33-bit subtraction: an address below the window wraps to a value with
    // bit 32 set, which the range compare rejects as well.
    assign w_off = {1'b0, w_ev_addr} - {1'b0, BASE_ADDR};
    assign w_idx = w_off[c_IDX_W+1:2];
    assign w_err = (w_ev_addr[1:0] != 2'b00) |
                   (w_ev_addr < BASE_ADDR)   |
                   (w_off >= c_SPAN)         |
                   (w_ev_sel == 4'b0000);

    // A write landing on an edge where reset is already asserted is dropped.
    assign w_mem_wr = w_commit & w_ev_we & ~w_err & ~rst_i;

    // Next-state decode and commit-point detection.
    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_req) begin
                    if (c_WAIT == 4'd0) begin
                        w_next_state = c_S_RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_next_state = c_S_WAIT;
                    end
                end
            end
            c_S_WAIT: begin
                if (!wbs_cyc_i) begin
                    w_next_state = c_S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_next_state = c_S_RESP;
                    w_commit     = 1'b1;
                end
            end
            c_S_RESP: w_next_state = c_S_TURN;
            c_S_TURN: w_next_state = c_S_IDLE;
            default:  w_next_state = c_S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture in IDLE and wait-state countdown.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= 4'd0;
            r_addr <= 32'h0;
            r_wdat <= 32'h0;
            r_sel  <= 4'h0;
            r_we   <= 1'b0;
        end else if (w_capture) begin
            r_cnt  <= c_WAIT;
            r_addr <= wbs_addr_i;
            r_wdat <= wbs_dat_i;
            r_sel  <= wbs_sel_i;
            r_we   <= wbs_we_i;
        end else if (r_state == c_S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response registers: ack/err pulse for the single RESP cycle, read data
    // held until the next successful read and cleared on error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_rdat <= 32'h0;
        end else begin
            r_ack <= w_commit & ~w_err;
            r_err <= w_commit & w_err;
            if (w_commit) begin
                if (w_err) begin
                    r_rdat <= 32'h0;
                end else if (!w_ev_we) begin
                    r_rdat <= r_mem[w_idx];
                end
            end
        end
    end

    // RAM write port with per-byte lane enables; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (w_mem_wr) begin
            for (int l = 0; l < 4; l++) begin
                if (w_ev_sel[l]) begin
                    r_mem[w_idx][8*l +: 8] <= w_ev_wdat[8*l +: 8];
                end
            end
        end
    end

    assign wbs_dat_o = r_rdat;
    assign wbs_ack_o = r_ack;
    assign wbs_err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_ram_slave
// Brief    : Self-checking bench for wb_ram_slave. Two instances (1 and 3
//            wait states) share clock and reset; each has its own bus.
//            Directed vector table, random traffic against a word-array
//            reference model, and hand-written abort / async-reset /
//            back-to-back sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_ram_slave;

    localparam logic [31:0] c_BASE  = 32'h0000_1000;
    localparam int          c_DEPTH = 16;
    localparam int          c_SPAN  = c_DEPTH * 4;

    logic        clk;
    logic        rst;
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic [1:0]  we;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [3:0]  sel   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdat  [2];
    logic [31:0] rdat  [2];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: plain word array per instance plus the last data
    // word each instance should be presenting.
    logic [31:0] m_mem  [2][c_DEPTH];
    logic [31:0] m_dato [2];

    wb_ram_slave #(.BASE_ADDR(c_BASE), .DEPTH_WORDS(c_DEPTH), .WAIT_STATES(1)) u_dut_ws1 (
        .clk_i(clk), .rst_i(rst),
        .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
        .wbs_addr_i(addr[0]), .wbs_dat_i(wdat[0]), .wbs_sel_i(sel[0]),
        .wbs_dat_o(rdat[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0])
    );

    wb_ram_slave #(.BASE_ADDR(c_BASE), .DEPTH_WORDS(c_DEPTH), .WAIT_STATES(3)) u_dut_ws3 (
        .clk_i(clk), .rst_i(rst),
        .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
        .wbs_addr_i(addr[1]), .wbs_dat_i(wdat[1]), .wbs_sel_i(sel[1]),
        .wbs_dat_o(rdat[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit exp_error(input logic [31:0] a, input logic [3:0] s);
        longint off;
        off = longint'({32'h0, a}) - longint'({32'h0, c_BASE});
        return (a % 4 != 0) || (off < 0) || (off >= c_SPAN) || (s == 4'b0000);
    endfunction

    task automatic model_apply(input int d, input bit w, input logic [31:0] a,
                               input logic [31:0] dt, input logic [3:0] s);
        int idx;
        if (exp_error(a, s)) begin
            m_dato[d] = 32'h0;
        end else begin
            idx = int'((a - c_BASE) / 4);
            if (w) begin
                for (int l = 0; l < 4; l++)
                    if (s[l]) m_mem[d][idx][8*l +: 8] = dt[8*l +: 8];
            end else begin
                m_dato[d] = m_mem[d][idx];
            end
        end
    endtask

    // One transaction, entered and left with the slave idle, #1 after an edge.
    // lat counts edges from request presentation to ack/err visible; the
    // first of those edges is the capture edge. Returns 0 on timeout.
    task automatic xfer(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] dt, input logic [3:0] s,
                        output bit got_ack, output bit got_err, output int lat);
        got_ack = 1'b0;
        got_err = 1'b0;
        lat     = 0;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
        addr[d] = a; wdat[d] = dt; sel[d] = s;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ack[d] || err[d]) begin
                got_ack = ack[d];
                got_err = err[d];
                lat     = n;
                break;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        @(posedge clk); #1;
        chk("pulse_width", {30'h0, ack[d], err[d]}, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic run_checked(input int d, input bit w, input logic [31:0] a,
                               input logic [31:0] dt, input logic [3:0] s);
        bit e, ga, ge;
        int lat;
        e = exp_error(a, s);
        xfer(d, w, a, dt, s, ga, ge, lat);
        model_apply(d, w, a, dt, s);
        chk("rand_ack", 32'(ga), 32'(!e));
        chk("rand_err", 32'(ge), 32'(e));
        chk("rand_latency", 32'(lat), 32'(ws_of(d) + 1));
        chk("rand_dat_o", rdat[d], m_dato[d]);
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] dt;
        logic [3:0]  s;
        bit          exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    initial begin
        vec_t vt [11];
        bit   ga, ge;
        int   lat, bad, first, second, acks, extra;
        logic [31:0] a, dt;
        logic [3:0]  s;

        rst = 1'b1;
        cyc = '0; stb = '0; we = '0;
        for (int d = 0; d < 2; d++) begin
            sel[d] = 4'h0; addr[d] = 32'h0; wdat[d] = 32'h0;
            m_dato[d] = 32'h0;
            for (int i = 0; i < c_DEPTH; i++) m_mem[d][i] = 32'h0;
        end

        // Directed vectors on the 1-wait-state instance.
        vt[0]  = '{1'b1, c_BASE + 32'h08, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000};
        vt[1]  = '{1'b0, c_BASE + 32'h08, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, c_BASE + 32'h08, 32'h0000_5500, 4'h2, 1'b0, 32'hDEAD_BEEF};
        vt[3]  = '{1'b0, c_BASE + 32'h08, 32'h0,         4'hF, 1'b0, 32'hDEAD_55EF};
        vt[4]  = '{1'b0, c_BASE + 32'h02, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
        vt[5]  = '{1'b0, c_BASE + 32'h40, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
        vt[6]  = '{1'b1, c_BASE + 32'h08, 32'h1234_5678, 4'h0, 1'b1, 32'h0000_0000};
        vt[7]  = '{1'b0, c_BASE + 32'h08, 32'h0,         4'hF, 1'b0, 32'hDEAD_55EF};
        vt[8]  = '{1'b0, c_BASE - 32'h04, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
        vt[9]  = '{1'b1, c_BASE + 32'h3C, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0000_0000};
        vt[10] = '{1'b0, c_BASE + 32'h3C, 32'h0,         4'hF, 1'b0, 32'hA5A5_A5A5};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ack", 32'(ack[d]), 32'h0);
            chk("reset_err", 32'(err[d]), 32'h0);
            chk("reset_dat_o", rdat[d], 32'h0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            xfer(0, vt[i].w, vt[i].a, vt[i].dt, vt[i].s, ga, ge, lat);
            model_apply(0, vt[i].w, vt[i].a, vt[i].dt, vt[i].s);
            chk($sformatf("vec%0d_ack", i), 32'(ga), 32'(!vt[i].exp_err));
            chk($sformatf("vec%0d_err", i), 32'(ge), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_dat_o", i), rdat[0], vt[i].exp_dat);
        end

        // Fill both RAMs so every word has a known value.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < c_DEPTH; i++)
                run_checked(d, 1'b1, c_BASE + 32'(4 * i), $urandom(), 4'hF);

        // Random traffic, including misaligned, out-of-window and sel=0.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 60; k++) begin
                a  = c_BASE - 32'd8 + 32'($urandom_range(0, c_SPAN + 16));
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                dt = $urandom();
                s  = 4'($urandom_range(0, 15));
                run_checked(d, 1'($urandom_range(0, 1)), a, dt, s);
            end
        end

        // Abort: 3 wait states, cyc dropped before the second WAIT edge.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        addr[1] = c_BASE + 32'h4; wdat[1] = ~m_mem[1][1]; sel[1] = 4'hF;
        @(posedge clk); #1;   // capture edge
        @(posedge clk); #1;   // first WAIT edge
        cyc[1] = 1'b0; stb[1] = 1'b0;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack[1] || err[1]) bad++;
        end
        chk("abort_no_response", 32'(bad), 32'h0);
        run_checked(1, 1'b0, c_BASE + 32'h4, 32'h0, 4'hF);
        chk("abort_old_value", rdat[1], m_mem[1][1]);

        // Asynchronous reset while ack is high.
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0;
        addr[0] = c_BASE + 32'h8; sel[0] = 4'hF;
        ga = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (ack[0]) begin ga = 1'b1; break; end
        end
        chk("rst_pre_ack", 32'(ga), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ack", 32'(ack[0]), 32'h0);
        chk("rst_async_dat_o", rdat[0], 32'h0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_dato[0] = 32'h0;
        m_dato[1] = 32'h0;
        chk("rst_other_dat_o", rdat[1], 32'h0);
        @(posedge clk); #1;
        run_checked(0, 1'b0, c_BASE + 32'h8, 32'h0, 4'hF);

        // Back-to-back reads with cyc/stb held across ack.
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0;
        addr[0] = c_BASE + 32'hC; sel[0] = 4'hF;
        first = -1; second = -1; acks = 0; bad = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (err[0]) bad++;
            if (ack[0]) begin
                acks++;
                if (first < 0) first = n; else second = n;
            end
            if (acks == 2) break;
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack[0] || err[0]) extra++;
        end
        chk("b2b_ack_count", 32'(acks + extra), 32'd2);
        chk("b2b_gap", 32'(second - first - 1), 32'(ws_of(0) + 2));
        chk("b2b_no_err", 32'(bad), 32'h0);
        chk("b2b_dat_o", rdat[0], m_mem[0][3]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_ram_slave.md
Name: wb_ram_slave

Overview:
- Wishbone B4 classic slave: the memory-side responder for the pipeline's Wishbone master bridge.
- Decodes a configurable address window onto an internal word-organised RAM.
- Inserts programmable wait states, applies byte-lane selects on writes, and returns registered ack/err plus read data.
- Sits on the memory side of the bus, directly driven by the master's cyc/stb/we/sel/addr/dat outputs.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, 2..65536.
- WAIT_STATES, 1, extra cycles inserted between request capture and ack/err; 0..15.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe; a request is valid only when cyc and stb are both high.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_addr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_sel_i  in  4  byte-lane select; bit n maps to dat[8n+7:8n].
- wbs_dat_o  out  32  read data, registered.
- wbs_ack_o  out  1  normal termination, one-cycle pulse, registered.
- wbs_err_o  out  1  error termination, one-cycle pulse, registered.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=32'h0, state=IDLE, wait counter=0. RAM contents are not reset.
- Reset mid-operation: outputs clear immediately, and any pending write is discarded.
- FSM states: IDLE, WAIT, RESP, TURN.
- IDLE:
  - On an edge with cyc&stb=1, capture addr/dat/sel/we into internal registers and load counter=WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else RESP.
- WAIT:
  - Counter decrements each edge; go to RESP on the edge where counter==1.
  - If cyc=0 on any edge in WAIT, return to IDLE: no ack, no err, no write (abort).
- Transition into RESP (single edge, the commit point):
  - Evaluate the captured request.
  - Error when any of: addr[1:0]!=0; addr<BASE_ADDR; addr-BASE_ADDR >= DEPTH_WORDS*4; sel==4'b0000.
  - On error: wbs_err_o<=1, wbs_dat_o<=0, no RAM write.
  - Else, write: RAM[index] lanes with sel=1 take wbs_dat_i lanes; other lanes are unchanged; wbs_ack_o<=1; wbs_dat_o unchanged.
  - Else, read: wbs_dat_o<=RAM[index] (full word regardless of sel); wbs_ack_o<=1.
  - index = (addr-BASE_ADDR)>>2, log2(DEPTH_WORDS) bits.
- RESP: ack/err are high for exactly this one cycle. The next edge clears both and goes to TURN.
- TURN: one cycle in which cyc/stb are ignored, because the registered master drops stb only after sampling ack. Next edge goes to IDLE.
- Ack and err are never both high. Neither is ever high outside RESP.
- Latency: capture edge to ack-high = WAIT_STATES+1 cycles. Peak throughput is one transfer per WAIT_STATES+3 cycles.
- Back-to-back: a request still present in IDLE after TURN is accepted normally. A master holding cyc high with stb low causes no action.
- wbs_dat_o holds the last read value until the next successful read; it is 0 after an error.
- Inputs are only sampled at capture in IDLE, so changes during WAIT/RESP have no effect except cyc=0 abort in WAIT.

Test Plan:
- Reset, then write addr=BASE+8, dat=32'hDEADBEEF, sel=4'hF, WAIT_STATES=1 -> ack high exactly 2 cycles after the capture edge, one cycle wide. Read BASE+8 -> wbs_dat_o=32'hDEADBEEF with ack.
- Byte write to BASE+8 with sel=4'b0010, dat=32'h0000_5500 -> subsequent read returns 32'hDEAD55EF.
- Read addr=BASE+2 (misaligned), then addr=BASE+DEPTH_WORDS*4 -> err pulse each, no ack, wbs_dat_o=0. A write with sel=0 -> err, and the RAM word is unchanged on readback.
- WAIT_STATES=3: drop cyc on the 2nd WAIT edge during a write to BASE+4 -> no ack/err. Readback of BASE+4 shows the old value.
- Assert rst_i asynchronously (between clock edges) during RESP -> ack falls immediately, not at the next edge. After release, the FSM is in IDLE and the next request completes normally.
- Master holds cyc&stb high across ack for two back-to-back reads -> exactly two acks, separated by WAIT_STATES+2 low cycles; no duplicate ack from TURN.
